// File: rtl/uart_receiver_if.sv
// ---------------------------------------------------------------------------
// uart_receiver_if
//   Valid/ready byte stream between the UART receiver buffer and its consumer.
//   o_data  : byte at the buffer head, meaningful only while o_valid is high
//   o_valid : buffer holds at least one byte
//   i_ready : consumer pops the head byte when o_valid && i_ready
//   master  : producer side (the receiver); slave : consumer side
// ---------------------------------------------------------------------------
interface uart_receiver_if;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;

    modport master (output o_data, output o_valid, input i_ready);
    modport slave  (input o_data, input o_valid, output i_ready);
endinterface

// File: rtl/uart_receiver.sv
// ---------------------------------------------------------------------------
// uart_receiver
//   8N1 serial receiver, LSB first, baud divider DIV = clk_freq_hz / baud_rate.
//   Received bytes are buffered behind a valid/ready handshake; framing errors
//   and overruns are reported as sticky flags.
//
// Ports
//   i_clk       : clock, all state changes on rising edge
//   i_rst       : synchronous active-high reset
//   i_uart_rx   : asynchronous serial line, idle high
//   rx_bus      : uart_receiver_if.master (o_data / o_valid / i_ready)
//   o_busy      : a frame is in progress (FSM not IDLE)
//   o_frame_err : sticky, stop bit sampled low
//   o_overrun   : sticky, byte dropped because the buffer was full
//   i_clear_err : clears both sticky flags (a same-cycle set wins)
//
// Build option
//   UART_RX_FIFO_EN : 4-entry circular FIFO instead of a single holding
//                     register. Handshake, flags and timing are identical.
// ---------------------------------------------------------------------------
module uart_receiver #(
    parameter int unsigned clk_freq_hz = 12000000,
    parameter int unsigned baud_rate   = 9600
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_uart_rx,
    uart_receiver_if.master rx_bus,
    output logic            o_busy,
    output logic            o_frame_err,
    output logic            o_overrun,
    input  logic            i_clear_err
);

    localparam int unsigned DIV   = clk_freq_hz / baud_rate;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(DIV - 1);

    if (DIV < 4) begin : g_div_check
        $error("uart_receiver: clk_freq_hz / baud_rate must be at least 4");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Line synchroniser. rx_sync2_q is the synchronised line, rx_prev_q its
    // one-cycle delay; all three reset to the idle level so that reset never
    // manufactures a falling edge on an idle line.
    // -----------------------------------------------------------------------
    logic rx_sync1_q, rx_sync2_q, rx_prev_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_sync1_q <= i_uart_rx;
            rx_sync2_q <= rx_sync1_q;
            rx_prev_q  <= rx_sync2_q;
        end
    end

    logic rxs;
    logic start_edge;
    assign rxs        = rx_sync2_q;
    // Edge-only trigger: a line stuck low (break) cannot restart reception.
    assign start_edge = rx_prev_q & ~rxs;

    // -----------------------------------------------------------------------
    // Receive FSM
    // -----------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             expiry;
    logic             push;
    logic             ferr_set;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        ferr_set  = 1'b0;
        expiry    = (state_q != S_IDLE) && (cnt_q == '0);

        if ((state_q != S_IDLE) && !expiry)
            cnt_d = cnt_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                // Half a bit to reach the middle of the start bit.
                if (start_edge) begin
                    cnt_d   = HALF_LOAD;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (expiry) begin
                    if (!rxs) begin
                        cnt_d     = FULL_LOAD;
                        bit_idx_d = '0;
                        state_d   = S_DATA;
                    end else begin
                        // Line back high mid start bit: glitch, drop it.
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (expiry) begin
                    // LSB arrives first, so shift in from the top.
                    shift_d   = {rxs, shift_q[7:1]};
                    cnt_d     = FULL_LOAD;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7)
                        state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (expiry) begin
                    state_d = S_IDLE;
                    if (rxs) push     = 1'b1;
                    else     ferr_set = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign o_busy = (state_q != S_IDLE);

    // -----------------------------------------------------------------------
    // Receive buffer. A push into a full buffer is only accepted when the
    // head is popped in the same cycle; otherwise the byte is dropped.
    // -----------------------------------------------------------------------
    logic       pop;
    logic       ovr_set;
    logic       buf_valid;
    logic [7:0] buf_data;

    assign pop = buf_valid & rx_bus.i_ready;

`ifdef UART_RX_FIFO_EN
    logic [3:0][7:0] mem_q, mem_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d;
    logic [1:0]      rd_ptr_q, rd_ptr_d;
    logic [2:0]      count_q, count_d;
    logic            full;
    logic            push_ok;

    assign full      = (count_q == 3'd4);
    assign buf_valid = (count_q != 3'd0);
    assign buf_data  = mem_q[rd_ptr_q];
    assign push_ok   = push & (~full | pop);
    assign ovr_set   = push & full & ~pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // When full with a pop, wr_ptr == rd_ptr: the head slot is read out
        // this cycle and overwritten at the edge, which is the intent.
        if (push_ok) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 2'd1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       valid_q, valid_d;
    logic       push_ok;

    assign buf_valid = valid_q;
    assign buf_data  = hold_q;
    assign push_ok   = push & (~valid_q | pop);
    assign ovr_set   = push & valid_q & ~pop;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        hold_d  = hold_q;
        valid_d = valid_q;
        if (push_ok) begin
            hold_d  = shift_q;
            valid_d = 1'b1;
        end else if (pop) begin
            valid_d = 1'b0;
        end
    end
`endif

    assign rx_bus.o_valid = buf_valid;
    assign rx_bus.o_data  = buf_data;

    // -----------------------------------------------------------------------
    // Sticky error flags; a set in the same cycle as a clear wins.
    // -----------------------------------------------------------------------
    logic frame_err_q, frame_err_d;
    logic overrun_q, overrun_d;

    always_comb begin
        frame_err_d = (frame_err_q & ~i_clear_err) | ferr_set;
        overrun_d   = (overrun_q & ~i_clear_err) | ovr_set;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule
